// File: rtl/bus_arbiter8_if.sv
// Handshake bundle between the eight requesters and the round-robin arbiter.
// The arbiter takes the slave side; the requester side is the master.
interface bus_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt_n;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt_n,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt_n,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/bus_arbiter8.sv
// Eight-way round-robin arbiter with active-low one-hot grant, hold limit
// and a single dead cycle between consecutive grants.
module bus_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter8_if.slave  bus
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [7:0]      gnt_n_q;
    logic [7:0]      gnt_n_d;
    logic [2:0]      sel_q;
    logic [2:0]      sel_d;
    logic            busy_q;
    logic            busy_d;
    logic            timeout_q;
    logic            timeout_d;
    logic [2:0]      ptr;
    logic [2:0]      ptr_d;
    logic [HW-1:0]   hcnt;
    logic [HW-1:0]   hcnt_d;

    logic            win_ok;
    logic [2:0]      win;
    logic [2:0]      idx;

    // First requester at or after the pointer, wrapping mod 8.
    always_comb begin
        win_ok = 1'b0;
        win    = ptr;
        idx    = ptr;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!win_ok && bus.req[idx]) begin
                win_ok = 1'b1;
                win    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state;
        gnt_n_d   = gnt_n_q;
        sel_d     = sel_q;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        hcnt_d    = hcnt;

        unique case (state)
            IDLE, RELEASE: begin
                if (win_ok) begin
                    state_d = GRANT;
                    sel_d   = win;
                    gnt_n_d = ~(8'b1 << win);
                    ptr_d   = win + 3'd1;
                    hcnt_d  = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_n_d = 8'hFF;
                end
            end
            GRANT: begin
                // An owner release always wins over the hold limit.
                if (bus.done || !bus.req[sel_q]) begin
                    state_d = RELEASE;
                    gnt_n_d = 8'hFF;
                end else if (hcnt == HMAX) begin
                    state_d   = RELEASE;
                    gnt_n_d   = 8'hFF;
                    timeout_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    hcnt_d = hcnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_n_d = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_n_q   <= 8'hFF;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr       <= 3'd0;
            hcnt      <= '0;
        end else begin
            state     <= state_d;
            gnt_n_q   <= gnt_n_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr       <= ptr_d;
            hcnt      <= hcnt_d;
        end
    end

    assign bus.gnt_n   = gnt_n_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8 with a hold limit of four cycles.
// Observed word is {gnt_n, sel, busy, timeout}.
module tb_bus_arbiter8;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    bus_arbiter8_if bus ();

    bus_arbiter8 #(
        .MAX_HOLD(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [12:0] obs;
    assign obs = {bus.gnt_n, bus.sel, bus.busy, bus.timeout};

    function automatic logic [12:0] pack(
        input logic [7:0] g,
        input logic [2:0] s,
        input logic       b,
        input logic       t
    );
        return {g, s, b, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        e = pack(8'hFF, 3'd0, 1'b0, 1'b0);
        reset    = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== e)
                $display("FAIL reset_hold[%0d] got %h want %h", i, obs, e);
            else
                passed++;
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs !== e)
                $display("FAIL reset_idle[%0d] got %h want %h", i, obs, e);
            else
                passed++;
        end
    endtask

    task automatic test_single();
        logic [12:0] exp_t [5];
        logic [12:0] e;
        exp_t[0] = pack(8'hF7, 3'd3, 1'b1, 1'b0);
        exp_t[1] = pack(8'hF7, 3'd3, 1'b1, 1'b0);
        exp_t[2] = pack(8'hF7, 3'd3, 1'b1, 1'b0);
        exp_t[3] = pack(8'hFF, 3'd3, 1'b0, 1'b0);
        exp_t[4] = pack(8'hF7, 3'd3, 1'b1, 1'b0);
        bus.req = 8'h08;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs !== exp_t[i])
                $display("FAIL single[%0d] got %h want %h", i, obs, exp_t[i]);
            else
                passed++;
            bus.done = (i == 2);
        end
        bus.req = 8'h00;
        tick();
        tick();
        e = pack(8'hFF, 3'd3, 1'b0, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL single_idle got %h want %h", obs, e);
        else
            passed++;
    endtask

    task automatic test_round_robin();
        logic [12:0] exp_t [8];
        exp_t[0] = pack(8'hFE, 3'd0, 1'b1, 1'b0);
        exp_t[1] = pack(8'hFF, 3'd0, 1'b0, 1'b0);
        exp_t[2] = pack(8'h7F, 3'd7, 1'b1, 1'b0);
        exp_t[3] = pack(8'hFF, 3'd7, 1'b0, 1'b0);
        exp_t[4] = pack(8'hFE, 3'd0, 1'b1, 1'b0);
        exp_t[5] = pack(8'hFF, 3'd0, 1'b0, 1'b0);
        exp_t[6] = pack(8'h7F, 3'd7, 1'b1, 1'b0);
        exp_t[7] = pack(8'hFF, 3'd7, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        bus.req  = 8'h81;
        bus.done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (obs !== exp_t[i])
                $display("FAIL rr[%0d] got %h want %h", i, obs, exp_t[i]);
            else
                passed++;
        end
        bus.req  = 8'h00;
        bus.done = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic [12:0] exp_t [6];
        exp_t[0] = pack(8'hFB, 3'd2, 1'b1, 1'b0);
        exp_t[1] = pack(8'hFB, 3'd2, 1'b1, 1'b0);
        exp_t[2] = pack(8'hFB, 3'd2, 1'b1, 1'b0);
        exp_t[3] = pack(8'hFB, 3'd2, 1'b1, 1'b0);
        exp_t[4] = pack(8'hFF, 3'd2, 1'b0, 1'b1);
        exp_t[5] = pack(8'hDF, 3'd5, 1'b1, 1'b0);
        bus.req = 8'h24;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (obs !== exp_t[i])
                $display("FAIL timeout[%0d] got %h want %h", i, obs, exp_t[i]);
            else
                passed++;
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_drop_and_limit();
        logic [12:0] e;
        bus.req = 8'h40;
        tick();
        tick();
        e = pack(8'hBF, 3'd6, 1'b1, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL drop_grant got %h want %h", obs, e);
        else
            passed++;
        bus.req = 8'h00;
        tick();
        e = pack(8'hFF, 3'd6, 1'b0, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL drop_release got %h want %h", obs, e);
        else
            passed++;
        tick();
        bus.req = 8'h40;
        for (int i = 0; i < 4; i++) tick();
        e = pack(8'hBF, 3'd6, 1'b1, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL limit_last got %h want %h", obs, e);
        else
            passed++;
        bus.done = 1'b1;
        tick();
        e = pack(8'hFF, 3'd6, 1'b0, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL done_on_limit got %h want %h", obs, e);
        else
            passed++;
        bus.done = 1'b0;
        bus.req  = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        bus.req = 8'h02;
        tick();
        e = pack(8'hFD, 3'd1, 1'b1, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL mid_pre got %h want %h", obs, e);
        else
            passed++;
        reset = 1'b1;
        tick();
        e = pack(8'hFF, 3'd0, 1'b0, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL mid_reset got %h want %h", obs, e);
        else
            passed++;
        reset   = 1'b0;
        bus.req = 8'hFF;
        tick();
        e = pack(8'hFE, 3'd0, 1'b1, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL mid_first got %h want %h", obs, e);
        else
            passed++;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        e = pack(8'hFD, 3'd1, 1'b1, 1'b0);
        total++;
        if (obs !== e)
            $display("FAIL mid_second got %h want %h", obs, e);
        else
            passed++;
        bus.req = 8'h00;
        tick();
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        reset    = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_drop_and_limit();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
